// File: rtl/defines_pkg.sv
`default_nettype none
// ============================================================================
// Module   : defines_pkg
// Desc     : Shared types and default sizes for the ping-pong buffer array.
// Revision : 1.0  initial release
// ============================================================================
package defines_pkg;

    typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;

    localparam int BUF_DATA_WIDTH = 16;
    localparam int BUF_DEPTH      = 16;

endpackage
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module   : memory
// Desc     : Simple dual-port RAM, one write port, registered read port.
// Revision : 1.0  initial release
// ============================================================================
module memory #(
    parameter  int WIDTH = 16,
    parameter  int SIZE  = 32,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data is only refreshed on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_buffer
// Desc     : Double-banked token buffer with commit/release toggles and
//            sticky schedule-violation flags.
// Revision : 1.0  initial release
// ============================================================================
module pingpong_buffer
    import defines_pkg::*;
#(
    parameter  int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter  int DEPTH      = BUF_DEPTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_toggle,
    input  logic                  rd_toggle,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic                  rd_avail,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [AW:0]           wr_level,
    output logic [AW:0]           rd_level,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bank_state_e bank_st_q  [2];
    bank_state_e bank_st_d  [2];
    logic [AW:0] bank_cnt_q [2];
    logic [AW:0] bank_cnt_d [2];
    logic        err_ov_q, err_ov_d;
    logic        err_un_q, err_un_d;
    logic        rd_valid_q;

    logic        wr_accept;
    logic        rd_accept;
    logic        release_ok;
    logic        commit_ok;
    logic [AW:0] wr_ptr_inc;

    assign wr_ready   = (wr_ptr_q < DEPTH_W);
    assign rd_avail   = (bank_st_q[rd_sel_q] == BANK_FULL) && (rd_ptr_q < bank_cnt_q[rd_sel_q]);
    assign wr_level   = wr_ptr_q;
    assign rd_level   = (bank_st_q[rd_sel_q] == BANK_FULL) ? (bank_cnt_q[rd_sel_q] - rd_ptr_q) : '0;

    assign wr_accept  = wr_valid & wr_ready;
    assign rd_accept  = rd_en & rd_avail;
    assign wr_ptr_inc = wr_ptr_q + {{AW{1'b0}}, wr_accept};
    assign release_ok = rd_toggle && (bank_st_q[rd_sel_q] == BANK_FULL);
    // The release is applied first, so freeing the other bank this cycle makes room.
    assign commit_ok  = (bank_st_q[~wr_sel_q] == BANK_EMPTY) || (release_ok && (rd_sel_q != wr_sel_q));

    always_comb begin
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        wr_ptr_d   = wr_ptr_inc;
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, rd_accept};
        bank_st_d  = bank_st_q;
        bank_cnt_d = bank_cnt_q;
        err_ov_d   = err_ov_q;
        err_un_d   = err_un_q;

        if (release_ok) begin
            bank_st_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d            = ~rd_sel_q;
            rd_ptr_d            = '0;
        end else if (rd_toggle) begin
            err_un_d = 1'b1;
        end

        if (wr_toggle) begin
            if (commit_ok) begin
                bank_st_d[wr_sel_q]  = BANK_FULL;
                bank_cnt_d[wr_sel_q] = wr_ptr_inc;
                wr_sel_d             = ~wr_sel_q;
                wr_ptr_d             = '0;
            end else begin
                err_ov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            bank_st_q[0]  <= BANK_EMPTY;
            bank_st_q[1]  <= BANK_EMPTY;
            bank_cnt_q[0] <= '0;
            bank_cnt_q[1] <= '0;
            err_ov_q      <= 1'b0;
            err_un_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            bank_st_q     <= bank_st_d;
            bank_cnt_q    <= bank_cnt_d;
            err_ov_q      <= err_ov_d;
            err_un_q      <= err_un_d;
            rd_valid_q    <= rd_accept;
        end
    end

    assign rd_valid      = rd_valid_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

    memory #(
        .WIDTH (DATA_WIDTH),
        .SIZE  (2*DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_accept),
        .waddr_i ({wr_sel_q, wr_ptr_q[AW-1:0]}),
        .wdata_i (wr_data),
        .re_i    (rd_accept),
        .raddr_i ({rd_sel_q, rd_ptr_q[AW-1:0]}),
        .rdata_o (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_buffer
// Desc     : Self-checking bench: directed table, corner sequences, random run.
// Revision : 1.0  initial release
// ============================================================================
module tb_pingpong_buffer;

    localparam int DW  = 16;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_toggle = 1'b0;
    logic          rd_toggle = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          wr_ready, rd_avail, rd_valid, err_overflow, err_underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   wr_level, rd_level;

    always #5 clk = ~clk;

    pingpong_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_toggle     (wr_toggle),
        .rd_toggle     (rd_toggle),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_en         (rd_en),
        .rd_avail      (rd_avail),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .wr_level      (wr_level),
        .rd_level      (rd_level),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the pending write frame, at most one committed frame.
    logic [DW-1:0] m_wq[$];
    logic [DW-1:0] m_frame[$];
    bit            m_have = 0;
    int            m_ridx = 0;
    bit            m_ov = 0, m_un = 0, m_rv = 0;
    logic [DW-1:0] m_rd = '0;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit wready, avail;
        if (rst) begin
            m_wq.delete(); m_frame.delete();
            m_have = 0; m_ridx = 0; m_ov = 0; m_un = 0; m_rv = 0; m_rd = '0;
            return;
        end
        wready = (m_wq.size() < DEP);
        avail  = m_have && (m_ridx < m_frame.size());
        m_rv   = rd_en && avail;
        if (m_rv) begin
            m_rd = m_frame[m_ridx];
            m_ridx++;
        end
        if (wr_valid && wready) m_wq.push_back(wr_data);
        if (rd_toggle) begin
            if (m_have) begin
                m_have = 0; m_frame.delete(); m_ridx = 0;
            end else begin
                m_un = 1;
            end
        end
        if (wr_toggle) begin
            if (!m_have) begin
                m_frame = m_wq; m_wq.delete(); m_have = 1; m_ridx = 0;
            end else begin
                m_ov = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int rl;
        rl = m_have ? (m_frame.size() - m_ridx) : 0;
        cmp({tag, ".wr_ready"}, int'(wr_ready), int'(m_wq.size() < DEP));
        cmp({tag, ".rd_avail"}, int'(rd_avail), int'(m_have && (m_ridx < m_frame.size())));
        cmp({tag, ".wr_level"}, int'(wr_level), m_wq.size());
        cmp({tag, ".rd_level"}, int'(rd_level), rl);
        cmp({tag, ".rd_valid"}, int'(rd_valid), int'(m_rv));
        cmp({tag, ".rd_data"}, int'(rd_data), int'(m_rd));
        cmp({tag, ".err_ov"}, int'(err_overflow), int'(m_ov));
        cmp({tag, ".err_un"}, int'(err_underflow), int'(m_un));
    endtask

    task automatic step(input string tag, input bit r, input bit wt, input bit rt,
                        input bit wv, input logic [DW-1:0] wd, input bit re);
        rst = r; wr_toggle = wt; rd_toggle = rt; wr_valid = wv; wr_data = wd; rd_en = re;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit            r, wt, rt, wv;
        logic [DW-1:0] wd;
        bit            re;
        bit            exp_wready, exp_avail;
        int            exp_wlevel, exp_rlevel;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 1, 16'h00A1, 0, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 16'h00A2, 0, 1, 0, 2, 0};
        tbl[3]  = '{0, 1, 0, 1, 16'h00A3, 0, 1, 1, 0, 3};
        tbl[4]  = '{0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, 2};
        tbl[5]  = '{0, 0, 0, 1, 16'h00B1, 1, 1, 1, 1, 1};
        tbl[6]  = '{0, 0, 1, 0, 16'h0000, 0, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 1, 0, 16'h0000, 0, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 16'h0000, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 16'h0000, 0, 1, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0};

        // Directed table: expectations from the table and from the model.
        for (int i = 0; i < 12; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].wt, tbl[i].rt, tbl[i].wv, tbl[i].wd, tbl[i].re);
            cmp($sformatf("tbl%0d.wr_ready_c", i), int'(wr_ready), int'(tbl[i].exp_wready));
            cmp($sformatf("tbl%0d.rd_avail_c", i), int'(rd_avail), int'(tbl[i].exp_avail));
            cmp($sformatf("tbl%0d.wr_level_c", i), int'(wr_level), tbl[i].exp_wlevel);
            cmp($sformatf("tbl%0d.rd_level_c", i), int'(rd_level), tbl[i].exp_rlevel);
        end

        // Basic ping-pong: tokens 1..16 out in order.
        step("pp.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEP; i++) step("pp.wr", 0, 0, 0, 1, DW'(i), 0);
        step("pp.commit", 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= DEP; i++) begin
            step("pp.rd", 0, 0, 0, 0, 0, 1);
            cmp("pp.rd_data_c", int'(rd_data), i);
        end
        step("pp.tail", 0, 0, 0, 0, 0, 0);

        // Full bank: 17th write held off.
        step("full.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEP + 1; i++) step("full.wr", 0, 0, 0, 1, DW'(16'h100 + i), 0);
        cmp("full.wr_level_c", int'(wr_level), DEP);
        cmp("full.wr_ready_c", int'(wr_ready), 0);

        // Overflow, then the refused bank's data survives a later commit.
        step("ov.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ov.wr0", 0, 0, 0, 1, DW'(16'h200 + i), 0);
        step("ov.commit0", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEP; i++) step("ov.wr1", 0, 0, 0, 1, DW'(16'h300 + i), 0);
        step("ov.bad", 0, 1, 0, 0, 0, 0);
        cmp("ov.err_c", int'(err_overflow), 1);
        cmp("ov.wr_level_c", int'(wr_level), DEP);
        step("ov.rel", 0, 0, 1, 0, 0, 0);
        step("ov.commit1", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEP; i++) step("ov.rd", 0, 0, 0, 0, 0, 1);
        cmp("ov.last_c", int'(rd_data), 16'h300 + DEP - 1);

        // Underflow straight after reset.
        step("un.rst", 1, 0, 0, 0, 0, 0);
        step("un.rel", 0, 0, 1, 0, 0, 0);
        cmp("un.err_c", int'(err_underflow), 1);
        cmp("un.avail_c", int'(rd_avail), 0);

        // Simultaneous commit and release.
        step("sim.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("sim.wr0", 0, 0, 0, 1, DW'(16'h400 + i), 0);
        step("sim.commit0", 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("sim.wr1", 0, 0, 0, 1, DW'(16'h500 + i), 0);
        step("sim.both", 0, 1, 1, 0, 0, 0);
        cmp("sim.rd_level_c", int'(rd_level), 5);
        cmp("sim.err_ov_c", int'(err_overflow), 0);
        cmp("sim.err_un_c", int'(err_underflow), 0);
        for (int i = 0; i < 5; i++) step("sim.rd", 0, 0, 0, 0, 0, 1);

        // Reset in the cycle a read is accepted.
        step("rr.rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step("rr.wr", 0, 0, 0, 1, DW'(16'h600 + i), 0);
        step("rr.commit", 0, 1, 0, 0, 0, 0);
        step("rr.ov", 0, 1, 0, 0, 0, 0);
        step("rr.rd", 0, 0, 0, 0, 0, 1);
        step("rr.rstrd", 1, 0, 0, 0, 0, 1);
        cmp("rr.rd_valid_c", int'(rd_valid), 0);
        cmp("rr.err_ov_c", int'(err_overflow), 0);
        cmp("rr.rd_data_c", int'(rd_data), 0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                 DW'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pingpong_buffer.md
# pingpong_buffer

Double-banked token buffer for one dataflow channel, sitting directly downstream of the toggle controller: one instance per buffer, driven by that buffer's `buff_wr_toggle`/`buff_rd_toggle` pair. The producer actor fills the write bank while the consumer actor drains the read bank. The controller's write toggle commits the write bank to the consumer, and its read toggle releases the read bank back to the producer. Schedule violations are flagged as sticky errors rather than corrupting data.

## Interface
- `DATA_WIDTH`, 16, token width in bits
- `DEPTH`, 16, token capacity of each bank; power of two, ≥2
- `AW`, `$clog2(DEPTH)`, pointer width (derived; not overridden)

- `clk`  in  1  rising-edge clock; one clock domain
- `rst`  in  1  reset, synchronous and active-high
- `wr_toggle`  in  1  single-cycle pulse from the controller: commit the write bank
- `rd_toggle`  in  1  single-cycle pulse from the controller: release the read bank
- `wr_valid`  in  1  producer presents `wr_data`
- `wr_data`  in  DATA_WIDTH  producer token
- `wr_ready`  out  1  write bank can accept a token
- `rd_en`  in  1  consumer read request
- `rd_avail`  out  1  an unread token exists in the committed read bank
- `rd_data`  out  DATA_WIDTH  token returned for an accepted read
- `rd_valid`  out  1  `rd_data` is valid this cycle
- `wr_level`  out  AW+1  tokens written into the current write bank
- `rd_level`  out  AW+1  tokens remaining in the current read bank (0 if it is not committed)
- `err_overflow`  out  1  sticky flag: a commit was refused
- `err_underflow`  out  1  sticky flag: a release was refused

## Operation
- State:
  - `wr_sel`, `rd_sel`: bank select bits.
  - `wr_ptr`, `rd_ptr`: AW+1-bit pointers.
  - Per bank: `bank_st` ∈ {BANK_EMPTY, BANK_FULL} and `bank_cnt` (AW+1 bits).
- Write: a token is accepted when `wr_valid & wr_ready`. It goes to address {`wr_sel`, `wr_ptr[AW-1:0]`} and `wr_ptr` increments.
  - `wr_ready = (wr_ptr < DEPTH)`. Writes are never dropped silently.
- Commit (`wr_toggle`):
  - Legal if bank `~wr_sel` is BANK_EMPTY, or is being released this same cycle.
  - If legal: bank[`wr_sel`] becomes BANK_FULL, `bank_cnt` = `wr_ptr` (including a write accepted this cycle), `wr_sel` flips, `wr_ptr` = 0.
  - If illegal: `err_overflow` sets, no swap, and the write bank keeps its contents.
  - A commit with `wr_ptr`=0 is legal and yields a zero-token bank.
- Read:
  - `rd_avail = (bank_st[rd_sel]==BANK_FULL) & (rd_ptr < bank_cnt[rd_sel])`.
  - `rd_en & rd_avail` is accepted: `rd_ptr` increments and the token is returned next cycle.
  - `rd_en` without `rd_avail` is ignored: no error, no `rd_valid`.
- Release (`rd_toggle`):
  - Legal if bank[`rd_sel`] is BANK_FULL.
  - If legal: the bank becomes BANK_EMPTY, `rd_sel` flips, `rd_ptr` = 0. Unread tokens are discarded.
  - If illegal: `err_underflow` sets and nothing changes.
  - A read accepted in the same cycle as the release still returns its data.
- Simultaneous commit and release: the release is applied first, so a commit that depends on the released bank succeeds.
- Error flags clear only on `rst`.

## Timing
- Reset values: `wr_sel`=`rd_sel`=0, pointers 0, both banks BANK_EMPTY, `rd_valid`=0, `rd_data`=0, both error flags 0.
  - Resulting outputs: `wr_ready`=1, `rd_avail`=0, `wr_level`=`rd_level`=0.
- Write-to-storage latency is 1 cycle.
- Commit-to-`rd_avail` latency is 1 cycle: asserted the cycle after `wr_toggle`, provided `rd_sel` points at the committed bank.
- Read latency is 1 cycle: `rd_valid`/`rd_data` are registered, and `rd_data` holds its value when `rd_valid`=0.
- `wr_ready`, `rd_avail`, `wr_level` and `rd_level` are combinational from registered state only. No input-to-output combinational path exists.
- Reset asserted mid-transfer aborts everything at the next edge. A read in flight produces no `rd_valid`.

## Structure
- `defines_pkg` gets:
  - `typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e`
  - `BUF_DATA_WIDTH` and `BUF_DEPTH`, the defaults used by the top-level buffer array
- Storage is one instance of the team's `memory` module:
  - WIDTH=DATA_WIDTH, SIZE=2*DEPTH, address {bank, ptr}.
  - Its read port is synchronous with one-cycle latency, which directly provides the registered `rd_data`.
- Everything else (bank state, pointers, error logic) lives in `pingpong_buffer` itself.

## Test plan
- Basic ping-pong (DEPTH=16):
  - Stimulus: write tokens 1..16, pulse `wr_toggle`, then read 16 tokens.
  - Expect: `rd_data` = 1..16 in order, one cycle after each `rd_en`. `wr_ready` stays 1 on bank 1 throughout.
- Full bank: write 17 tokens. Expect `wr_ready`=0 after the 16th, the 17th held off, `wr_level`=16.
- Overflow:
  - Stimulus: commit bank 0, fill bank 1, then pulse `wr_toggle` with no release in between.
  - Expect: `err_overflow`=1, `wr_sel` unchanged, bank 1 data intact after a later release and commit.
- Underflow: pulse `rd_toggle` straight after reset. Expect `err_underflow`=1, `rd_avail`=0, no state change.
- Simultaneous events:
  - Stimulus: bank 0 committed, bank 1 holding 5 tokens; `wr_toggle` and `rd_toggle` pulsed in the same cycle.
  - Expect: no error, `rd_level`=5 on bank 1 next cycle, `wr_sel`=0.
- Reset mid-read:
  - Stimulus: assert `rst` in the cycle a read is accepted.
  - Expect: `rd_valid`=0 next cycle, all reset values restored, error flags cleared.
